// File: rtl/devil_pkg.sv
// devil_pkg: shared definitions for the devil controller snoop front end.
//   - snoop_state_t : capture FSM state encoding (IDLE, ISSUE, BUSY, BYPASS)
//   - snoop_entry_t : FIFO entry layout {match, acsnoop[3:0], acaddr}
//   - register bit constants for the global enable and the type wildcard
package devil_pkg;

  localparam int ACE_ADDR_W         = 44;
  localparam int DEVIL_EN_BIT       = 10;
  localparam int SNOOP_WILDCARD_BIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_BUSY   = 2'd2,
    ST_BYPASS = 2'd3
  } snoop_state_t;

  // The match verdict is frozen at push time so later register writes
  // cannot reclassify a snoop that is already queued.
  typedef struct packed {
    logic                  match;
    logic [3:0]            acsnoop;
    logic [ACE_ADDR_W-1:0] acaddr;
  } snoop_entry_t;

  localparam int ENTRY_W = $bits(snoop_entry_t);

endpackage

// File: rtl/ace_snoop_capture_fifo.sv
// snoop_fifo: parameterised synchronous FIFO for captured snoops.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata  write request and data (ignored while full)
//   pop          read request (ignored while empty)
//   rdata        current head entry (valid when !empty)
//   empty, full  occupancy flags derived from the registered count
//   ready        registered "not full next cycle", used directly as acready
module snoop_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  ready_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];
  assign ready   = ready_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are DEPTH_LOG2 wide so they wrap modulo the depth for free.
  // ready is computed from the next count, so a pop on a full FIFO only
  // reopens the input on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != (DEPTH_LOG2+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ace_snoop_capture.sv
// ace_snoop_capture: ACE AC-channel snoop capture stage of the devil controller.
// Accepts snoops, classifies them against an address window and type filter,
// queues them, and either fires the passive engine or hands them to a bypass
// responder.
// Ports:
//   ace_aclk, ace_aresetn                clock, asynchronous active-low reset
//   acvalid, acready, acaddr, acsnoop    ACE AC snoop address channel
//   i_control_reg                        bit DEVIL_EN enables matching
//   i_acsnoop_reg                        [3:0] type to match, [4] wildcard
//   i_base_addr_reg, i_addr_size_reg     match window (size 0 disables it)
//   o_acaddr_snapshot, o_acsnoop_snapshot  head entry (held while empty)
//   o_trigger_passive, i_end_passive     passive engine start pulse / done
//   o_bypass_valid, i_bypass_ready       unmatched head to bypass responder
//   o_busy                               FSM not idle
//   o_match_count, o_drop_count          saturating statistics
//   o_timeout                            sticky BUSY watchdog flag
// Optional build macro: SNOOP_WATCHDOG_EN enables the BUSY watchdog;
// without it o_timeout is tied low and BUSY waits indefinitely.
module ace_snoop_capture
  import devil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_ACE_ADDR_WIDTH   = ACE_ADDR_W,
  parameter int DEVIL_EN           = DEVIL_EN_BIT,
  parameter int FIFO_DEPTH_LOG2    = 2,
  parameter int TIMEOUT_CYCLES     = 4096
) (
  input  logic                          ace_aclk,
  input  logic                          ace_aresetn,
  input  logic                          acvalid,
  output logic                          acready,
  input  logic [C_ACE_ADDR_WIDTH-1:0]   acaddr,
  input  logic [3:0]                    acsnoop,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_control_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_acsnoop_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_base_addr_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_addr_size_reg,
  output logic [C_ACE_ADDR_WIDTH-1:0]   o_acaddr_snapshot,
  output logic [3:0]                    o_acsnoop_snapshot,
  output logic                          o_trigger_passive,
  input  logic                          i_end_passive,
  output logic                          o_bypass_valid,
  input  logic                          i_bypass_ready,
  output logic                          o_busy,
  output logic [31:0]                   o_match_count,
  output logic [31:0]                   o_drop_count,
  output logic                          o_timeout
);

  snoop_state_t state_q, state_d;

  snoop_entry_t push_entry;
  snoop_entry_t head_entry;
  logic         push;
  logic         pop;
  logic         fifo_empty;
  logic         fifo_full;

  logic [C_ACE_ADDR_WIDTH:0] addr_ext;
  logic [C_ACE_ADDR_WIDTH:0] base_ext;
  logic [C_ACE_ADDR_WIDTH:0] limit_ext;
  logic                      in_window;
  logic                      type_ok;

  logic                        end_pending_q;
  logic                        match_inc;
  logic [31:0]                 match_count_q;
  logic [31:0]                 drop_count_q;
  logic [C_ACE_ADDR_WIDTH-1:0] snap_addr_q;
  logic [3:0]                  snap_type_q;

  // Only a few register bits are meaningful; the rest are reserved.
  logic unused_regs;
  assign unused_regs = ^{i_control_reg, i_acsnoop_reg};

  assign push = acvalid && acready;

  // Window compare runs one bit wider than the address so base+size can
  // reach past the top of the 32-bit register range without wrapping.
  assign addr_ext  = {1'b0, acaddr};
  assign base_ext  = (C_ACE_ADDR_WIDTH+1)'(i_base_addr_reg);
  assign limit_ext = base_ext + (C_ACE_ADDR_WIDTH+1)'(i_addr_size_reg);
  assign in_window = (i_addr_size_reg != '0) && (addr_ext >= base_ext) &&
                     (addr_ext < limit_ext);
  assign type_ok   = i_acsnoop_reg[SNOOP_WILDCARD_BIT] ||
                     (acsnoop == i_acsnoop_reg[3:0]);

  always_comb begin
    push_entry         = '0;
    push_entry.match   = i_control_reg[DEVIL_EN] && in_window && type_ok;
    push_entry.acsnoop = acsnoop;
    push_entry.acaddr  = acaddr;
  end

  snoop_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (ace_aclk),
    .rst_n (ace_aresetn),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .empty (fifo_empty),
    .full  (fifo_full),
    .ready (acready)
  );

`ifdef SNOOP_WATCHDOG_EN
  logic [31:0] wd_cnt_q;
  logic        wd_expire;
  logic        timeout_q;
`endif

  // Next-state and per-state outputs.  The watchdog branch sits below the
  // end-of-passive test so a simultaneous done wins and raises no flag.
  always_comb begin
    state_d           = state_q;
    pop               = 1'b0;
    match_inc         = 1'b0;
    o_trigger_passive = 1'b0;
    o_bypass_valid    = 1'b0;
`ifdef SNOOP_WATCHDOG_EN
    wd_expire         = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = head_entry.match ? ST_ISSUE : ST_BYPASS;
      end
      ST_ISSUE: begin
        o_trigger_passive = 1'b1;
        match_inc         = 1'b1;
        state_d           = ST_BUSY;
      end
      ST_BUSY: begin
        if (i_end_passive || end_pending_q) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
`ifdef SNOOP_WATCHDOG_EN
        else if (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          pop       = 1'b1;
          wd_expire = 1'b1;
          state_d   = ST_IDLE;
        end
`endif
      end
      ST_BYPASS: begin
        o_bypass_valid = 1'b1;
        if (i_bypass_ready) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus the one-shot memory for a done pulse that lands
  // in the ISSUE cycle; it is consumed on the first BUSY cycle.
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      state_q       <= ST_IDLE;
      end_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      end_pending_q <= (state_q == ST_ISSUE) && i_end_passive;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      match_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      if (match_inc && (match_count_q != '1))
        match_count_q <= match_count_q + 1'b1;
      if (acvalid && fifo_full && (drop_count_q != '1))
        drop_count_q <= drop_count_q + 1'b1;
    end
  end

  // Remember the last head so the snapshot holds steady once the FIFO drains.
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      snap_addr_q <= '0;
      snap_type_q <= '0;
    end else if (!fifo_empty) begin
      snap_addr_q <= head_entry.acaddr;
      snap_type_q <= head_entry.acsnoop;
    end
  end

  assign o_acaddr_snapshot  = fifo_empty ? snap_addr_q : head_entry.acaddr;
  assign o_acsnoop_snapshot = fifo_empty ? snap_type_q : head_entry.acsnoop;
  assign o_busy             = (state_q != ST_IDLE);
  assign o_match_count      = match_count_q;
  assign o_drop_count       = drop_count_q;

`ifdef SNOOP_WATCHDOG_EN
  // Watchdog counts consecutive BUSY cycles, restarting on every entry.
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= ((state_q == ST_BUSY) && (state_d == ST_BUSY)) ?
                   wd_cnt_q + 1'b1 : '0;
      timeout_q <= timeout_q | wd_expire;
    end
  end
  assign o_timeout = timeout_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign o_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_ace_snoop_capture.sv
// tb_ace_snoop_capture: directed self-checking bench for ace_snoop_capture.
// Steps run linearly in one initial block; inputs change 1 time unit after a
// rising edge and outputs are checked at that same point.
module tb_ace_snoop_capture;

  logic        ace_aclk;
  logic        ace_aresetn;
  logic        acvalid;
  logic        acready;
  logic [43:0] acaddr;
  logic [3:0]  acsnoop;
  logic [31:0] i_control_reg;
  logic [31:0] i_acsnoop_reg;
  logic [31:0] i_base_addr_reg;
  logic [31:0] i_addr_size_reg;
  logic [43:0] o_acaddr_snapshot;
  logic [3:0]  o_acsnoop_snapshot;
  logic        o_trigger_passive;
  logic        i_end_passive;
  logic        o_bypass_valid;
  logic        i_bypass_ready;
  logic        o_busy;
  logic [31:0] o_match_count;
  logic [31:0] o_drop_count;
  logic        o_timeout;

  int vectors;
  int miscompares;
  int send_idx;

  ace_snoop_capture dut (
    .ace_aclk           (ace_aclk),
    .ace_aresetn        (ace_aresetn),
    .acvalid            (acvalid),
    .acready            (acready),
    .acaddr             (acaddr),
    .acsnoop            (acsnoop),
    .i_control_reg      (i_control_reg),
    .i_acsnoop_reg      (i_acsnoop_reg),
    .i_base_addr_reg    (i_base_addr_reg),
    .i_addr_size_reg    (i_addr_size_reg),
    .o_acaddr_snapshot  (o_acaddr_snapshot),
    .o_acsnoop_snapshot (o_acsnoop_snapshot),
    .o_trigger_passive  (o_trigger_passive),
    .i_end_passive      (i_end_passive),
    .o_bypass_valid     (o_bypass_valid),
    .i_bypass_ready     (i_bypass_ready),
    .o_busy             (o_busy),
    .o_match_count      (o_match_count),
    .o_drop_count       (o_drop_count),
    .o_timeout          (o_timeout)
  );

  initial ace_aclk = 1'b0;
  always #5 ace_aclk = ~ace_aclk;

  // Global guard so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  function automatic logic [43:0] addrOf(input int i);
    return 44'h1000 + 44'(i * 16);
  endfunction

  task automatic tick();
    @(posedge ace_aclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [43:0] addr,
                               input logic [3:0] typ);
    acvalid = valid;
    acaddr  = addr;
    acsnoop = typ;
  endtask

  // One handshake: acready must already be high, push happens on this edge.
  task automatic sendSnoop(input string tag, input logic [43:0] addr,
                           input logic [3:0] typ);
    checkOutput({tag, " acready"}, 64'(acready), 64'd1);
    applyStimulus(1'b1, addr, typ);
    tick();
    acvalid = 1'b0;
  endtask

  // Called right after the push edge: IDLE cycle, then ISSUE, then BUSY.
  task automatic expectTrigger(input string tag);
    checkOutput({tag, " idle no trigger"}, 64'(o_trigger_passive), 64'd0);
    tick();
    checkOutput({tag, " trigger"}, 64'(o_trigger_passive), 64'd1);
    checkOutput({tag, " no bypass"}, 64'(o_bypass_valid), 64'd0);
    tick();
    checkOutput({tag, " single pulse"}, 64'(o_trigger_passive), 64'd0);
    checkOutput({tag, " busy"}, 64'(o_busy), 64'd1);
    i_end_passive = 1'b1;
    tick();
    i_end_passive = 1'b0;
    checkOutput({tag, " released"}, 64'(o_busy), 64'd0);
  endtask

  // Called right after the push edge: IDLE cycle, then BYPASS held.
  task automatic expectBypass(input string tag);
    tick();
    checkOutput({tag, " bypass_valid"}, 64'(o_bypass_valid), 64'd1);
    checkOutput({tag, " no trigger"}, 64'(o_trigger_passive), 64'd0);
    tick();
    checkOutput({tag, " bypass held"}, 64'(o_bypass_valid), 64'd1);
    i_bypass_ready = 1'b1;
    tick();
    i_bypass_ready = 1'b0;
    checkOutput({tag, " bypass done"}, 64'(o_bypass_valid), 64'd0);
    checkOutput({tag, " idle"}, 64'(o_busy), 64'd0);
  endtask

  task automatic tickWithSnoop();
    logic acc;
    acc = acvalid && acready;
    tick();
    if (acc) begin
      send_idx++;
      if (send_idx < 6) acaddr = addrOf(send_idx);
      else acvalid = 1'b0;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " acready"}, 64'(acready), 64'd0);
    checkOutput({tag, " trigger"}, 64'(o_trigger_passive), 64'd0);
    checkOutput({tag, " bypass"}, 64'(o_bypass_valid), 64'd0);
    checkOutput({tag, " busy"}, 64'(o_busy), 64'd0);
    checkOutput({tag, " match_count"}, 64'(o_match_count), 64'd0);
    checkOutput({tag, " drop_count"}, 64'(o_drop_count), 64'd0);
    checkOutput({tag, " snap addr"}, 64'(o_acaddr_snapshot), 64'd0);
    checkOutput({tag, " snap type"}, 64'(o_acsnoop_snapshot), 64'd0);
    checkOutput({tag, " timeout"}, 64'(o_timeout), 64'd0);
  endtask

  initial begin
    int waited;
    vectors         = 0;
    miscompares     = 0;
    send_idx        = 0;
    ace_aresetn     = 1'b0;
    acvalid         = 1'b0;
    acaddr          = '0;
    acsnoop         = '0;
    i_control_reg   = 32'h0000_0400;
    i_acsnoop_reg   = 32'h1;
    i_base_addr_reg = 32'h1000;
    i_addr_size_reg = 32'h100;
    i_end_passive   = 1'b0;
    i_bypass_ready  = 1'b0;

    // Reset state
    repeat (2) tick();
    checkResetOutputs("reset");
    ace_aresetn = 1'b1;
    tick();
    checkOutput("post reset acready", 64'(acready), 64'd1);

    // Stray done pulse while idle must be ignored
    i_end_passive = 1'b1;
    tick();
    i_end_passive = 1'b0;
    checkOutput("stray end idle", 64'(o_busy), 64'd0);

    // Basic matched snoop: 2-cycle trigger latency, busy until done
    sendSnoop("t1", 44'h1040, 4'h1);
    checkOutput("t1 idle no trigger", 64'(o_trigger_passive), 64'd0);
    checkOutput("t1 snap addr", 64'(o_acaddr_snapshot), 64'h1040);
    checkOutput("t1 snap type", 64'(o_acsnoop_snapshot), 64'h1);
    tick();
    checkOutput("t1 trigger", 64'(o_trigger_passive), 64'd1);
    tick();
    checkOutput("t1 single pulse", 64'(o_trigger_passive), 64'd0);
    checkOutput("t1 match_count", 64'(o_match_count), 64'd1);
    repeat (3) tick();
    checkOutput("t1 busy waits", 64'(o_busy), 64'd1);
    i_end_passive = 1'b1;
    tick();
    i_end_passive = 1'b0;
    checkOutput("t1 released", 64'(o_busy), 64'd0);
    checkOutput("t1 snap held", 64'(o_acaddr_snapshot), 64'h1040);

    // Window edges: 0x10FF inside, 0x1100 just past the end
    sendSnoop("t2a", 44'h10FF, 4'h1);
    sendSnoop("t2b", 44'h1100, 4'h1);
    checkOutput("t2 trigger", 64'(o_trigger_passive), 64'd1);
    checkOutput("t2 snap first", 64'(o_acaddr_snapshot), 64'h10FF);
    tick();
    i_end_passive = 1'b1;
    tick();
    i_end_passive = 1'b0;
    tick();
    checkOutput("t2 bypass_valid", 64'(o_bypass_valid), 64'd1);
    checkOutput("t2 snap second", 64'(o_acaddr_snapshot), 64'h1100);
    repeat (2) tick();
    checkOutput("t2 bypass held", 64'(o_bypass_valid), 64'd1);
    i_bypass_ready = 1'b1;
    tick();
    i_bypass_ready = 1'b0;
    checkOutput("t2 bypass done", 64'(o_bypass_valid), 64'd0);
    checkOutput("t2 match_count", 64'(o_match_count), 64'd2);

    // Filter disable paths
    i_addr_size_reg = 32'h0;
    sendSnoop("t3 size0", 44'h1040, 4'h1);
    expectBypass("t3 size0");
    i_addr_size_reg = 32'h100;
    i_control_reg   = 32'h0;
    sendSnoop("t3 noen", 44'h1040, 4'h1);
    expectBypass("t3 noen");
    i_control_reg = 32'h0000_0400;
    i_acsnoop_reg = 32'h2;
    sendSnoop("t3 type", 44'h1040, 4'h1);
    expectBypass("t3 type");
    i_acsnoop_reg = 32'h10;
    sendSnoop("t3 wild", 44'h1080, 4'h7);
    checkOutput("t3 wild snap type", 64'(o_acsnoop_snapshot), 64'h7);
    expectTrigger("t3 wild");
    i_acsnoop_reg = 32'h1;

    // Register change after push does not reclassify the queued snoop
    sendSnoop("t3 late", 44'h1040, 4'h1);
    i_addr_size_reg = 32'h0;
    expectTrigger("t3 late");
    i_addr_size_reg = 32'h100;

    // High window must not wrap at 32 bits
    i_base_addr_reg = 32'hFFFF_FF00;
    i_addr_size_reg = 32'h200;
    sendSnoop("t4", 44'h1_0000_0080, 4'h1);
    expectTrigger("t4");
    checkOutput("t4 match_count", 64'(o_match_count), 64'd5);
    i_base_addr_reg = 32'h1000;
    i_addr_size_reg = 32'h100;

    // Fill with passive engine stalled, count drops, then drain in order
    for (int i = 0; i < 4; i++) sendSnoop("t5 fill", addrOf(i), 4'h1);
    checkOutput("t5 acready full", 64'(acready), 64'd0);
    send_idx = 4;
    applyStimulus(1'b1, addrOf(4), 4'h1);
    repeat (5) tick();
    checkOutput("t5 drop_count", 64'(o_drop_count), 64'd5);
    checkOutput("t5 still full", 64'(acready), 64'd0);
    checkOutput("t5 head", 64'(o_acaddr_snapshot), 64'(addrOf(0)));
    i_end_passive = 1'b1;
    tickWithSnoop();
    i_end_passive = 1'b0;
    checkOutput("t5 drop after pop", 64'(o_drop_count), 64'd6);
    checkOutput("t5 acready reopens", 64'(acready), 64'd1);
    for (int k = 1; k < 6; k++) begin
      waited = 0;
      while (!o_trigger_passive && waited < 10) begin
        tickWithSnoop();
        waited++;
      end
      checkOutput($sformatf("t5 order trigger %0d", k), 64'(o_trigger_passive), 64'd1);
      checkOutput($sformatf("t5 order addr %0d", k), 64'(o_acaddr_snapshot), 64'(addrOf(k)));
      i_end_passive = 1'b1;
      tickWithSnoop();
      i_end_passive = 1'b0;
    end
    tick();
    checkOutput("t5 drained", 64'(o_busy), 64'd0);
    checkOutput("t5 match_count", 64'(o_match_count), 64'd11);

    // Reset mid-BUSY with three entries queued behind the head
    for (int i = 0; i < 4; i++) sendSnoop("t6 fill", addrOf(i), 4'h1);
    repeat (2) tick();
    checkOutput("t6 busy before reset", 64'(o_busy), 64'd1);
    ace_aresetn = 1'b0;
    #1;
    checkResetOutputs("t6 reset");
    tick();
    ace_aresetn = 1'b1;
    tick();
    checkOutput("t6 acready", 64'(acready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t6 no trigger", 64'(o_trigger_passive), 64'd0);
      checkOutput("t6 no bypass", 64'(o_bypass_valid), 64'd0);
      checkOutput("t6 idle", 64'(o_busy), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ace_snoop_capture.md
Name: ace_snoop_capture

Overview:
- Upstream stage of the devil controller, on the ACE AC (snoop address) channel.
- Accepts snoops via the acvalid/acready handshake and buffers them in a small FIFO.
- Classifies each snoop against the address window and snoop-type filter, then presents the head entry as the snapshot address and type.
- Matched snoops get a one-cycle passive trigger and are held until the passive engine ends; unmatched snoops go to a bypass responder.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, width of the control/filter registers.
- C_ACE_ADDR_WIDTH, 44, snoop address width.
- DEVIL_EN, 10, bit index of the global enable in i_control_reg.
- FIFO_DEPTH_LOG2, 2, log2 of the snoop FIFO depth (4 entries).
- TIMEOUT_CYCLES, 4096, BUSY watchdog limit (used only with the optional feature).

Ports:
- ace_aclk  in  1  clock.
- ace_aresetn  in  1  reset; asynchronous, active-low.
- acvalid  in  1  AC valid.
- acready  out  1  AC ready.
- acaddr  in  C_ACE_ADDR_WIDTH  AC address.
- acsnoop  in  4  AC snoop type.
- i_control_reg  in  32  bit DEVIL_EN = filter enable.
- i_acsnoop_reg  in  32  [3:0] type to match; [4] = type wildcard.
- i_base_addr_reg  in  32  window base, zero-extended.
- i_addr_size_reg  in  32  window size in bytes; 0 = window disabled.
- o_acaddr_snapshot  out  C_ACE_ADDR_WIDTH  head entry address.
- o_acsnoop_snapshot  out  4  head entry type.
- o_trigger_passive  out  1  one-cycle pulse for a matched head.
- i_end_passive  in  1  passive engine done (pulse).
- o_bypass_valid  out  1  unmatched head offered to the bypass responder.
- i_bypass_ready  in  1  bypass responder accepts the head.
- o_busy  out  1  FSM not in IDLE.
- o_match_count  out  32  matched snoops, saturating.
- o_drop_count  out  32  cycles with acvalid high while the FIFO is full, saturating.
- o_timeout  out  1  sticky watchdog flag (optional feature).

Behaviour:
- Reset: every output is 0, FIFO empty, FSM in IDLE, counters 0. Asserting reset mid-operation discards all buffered entries; no trigger or bypass is emitted after reset deasserts until a new snoop is accepted.
- acready = !full, registered from the FIFO count. A push happens in any cycle with acvalid && acready.
- Match computation:
  - Computed at push time and stored with the entry.
  - Window: size != 0 and base <= acaddr < base+size. The compare is done in 45-bit arithmetic so base+size cannot wrap.
  - Type: i_acsnoop_reg[4] set, or acsnoop == i_acsnoop_reg[3:0].
  - Match requires the enable bit, the window test and the type test.
  - A register change affects only later pushes.
- Snapshot outputs always show the FIFO head and hold their value while the FIFO is empty.
- FSM states:
  - IDLE: when the FIFO is not empty, go to ISSUE if the head is matched, else go to BYPASS.
  - ISSUE: o_trigger_passive=1 for exactly one cycle; o_match_count increments; then BUSY.
  - BUSY: wait for i_end_passive, then pop and return to IDLE. An i_end_passive arriving in the ISSUE cycle is registered and honoured on entry to BUSY.
  - BYPASS: o_bypass_valid=1 and held stable until i_bypass_ready; pop on that cycle and return to IDLE.
- Latency: acvalid&&acready to o_trigger_passive is 2 cycles (push, IDLE decision, ISSUE).
- Back-to-back operation: at most one pop per cycle. Push and pop in the same cycle are allowed while full; acready stays low that cycle, since it is registered. Pointers wrap modulo depth.
- Counters saturate at 0xFFFFFFFF.
- A stray i_end_passive outside BUSY/ISSUE is ignored.

Optional Feature:
- Macro: SNOOP_WATCHDOG_EN.
- With it defined:
  - A counter runs only in BUSY.
  - When it reaches TIMEOUT_CYCLES, the FSM pops the head, sets o_timeout (cleared only by reset) and returns to IDLE.
  - A simultaneous i_end_passive takes priority: normal pop, no flag.
- Without it: BUSY waits indefinitely and o_timeout is tied to 0.

Decomposition:
- Package devil_pkg holds:
  - the FSM state encoding (IDLE, ISSUE, BUSY, BYPASS);
  - the FIFO entry layout {match, acsnoop[3:0], acaddr};
  - the register bit constants (DEVIL_EN index, wildcard bit 4).
- One sub-module, snoop_fifo: a parameterised synchronous FIFO with full/empty flags and registered count.

Test Plan:
- Base 0x1000, size 0x100, type 0x1, enable set; snoop 0x1040/0x1 -> trigger pulse 2 cycles after handshake, snapshot 0x1040/0x1, o_busy until i_end_passive, match_count=1.
- Snoop 0x10FF and 0x1100, type 0x1 -> first triggers; second asserts bypass_valid and holds it until i_bypass_ready; match_count=1.
- Size=0, or enable cleared, with the window-matching snoop 0x1040/0x1 -> bypass path, no trigger.
- Base 0xFFFFFF00, size 0x200, snoop 0x1_0000_0080 -> matches (no 32-bit wrap).
- Hold i_end_passive low and push 6 snoops -> acready low after the 4th, drop_count counts the stalled cycles, order preserved after release.
- Reset mid-BUSY with 3 entries queued -> all outputs 0, FIFO empty; with SNOOP_WATCHDOG_EN, TIMEOUT_CYCLES=16 -> pop and o_timeout=1 at cycle 16 of BUSY.
